// File: rtl/ps2_scancode_receiver_if.sv
// ps2_scancode_receiver_if
//   Bundle between the PS/2 pins/event consumer and ps2_scancode_receiver.
//   ps2clk_in, ps2data_in : raw asynchronous PS/2 pin levels (into receiver)
//   scan_received         : one-cycle strobe, scan/extended/released valid
//   scan, extended, released : last key event, held until the next one
//   frame_error           : one-cycle strobe on bad frame or timeout abort
//   busy                  : frame in progress
//   state_dbg             : current frame FSM state, for observation only
// Handshake: scan_received and frame_error are single-cycle strobes with no
// back-pressure; the consumer must take the event on the cycle the strobe
// is high, while scan/extended/released stay stable until the next strobe.
interface ps2_scancode_receiver_if;
   logic       ps2clk_in;
   logic       ps2data_in;
   logic       scan_received;
   logic [7:0] scan;
   logic       extended;
   logic       released;
   logic       frame_error;
   logic       busy;
   logic [1:0] state_dbg;

   modport master (
      output ps2clk_in, ps2data_in,
      input  scan_received, scan, extended, released, frame_error, busy, state_dbg
   );

   modport slave (
      input  ps2clk_in, ps2data_in,
      output scan_received, scan, extended, released, frame_error, busy, state_dbg
   );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver
//   Synchronises and deglitches the PS/2 clock/data pins, deserialises
//   11-bit frames, checks start/parity/stop, folds E0/F0 prefixes into the
//   extended/released flags and emits one strobe per qualified key event.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : ps2_scancode_receiver_if.slave (pins in, event outputs out)
module ps2_scancode_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int TO_W           = 16
) (
   input  logic clk,
   input  logic rst,
   ps2_scancode_receiver_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RECV, CHECK, DECODE} state_t;

   localparam logic [3:0]      FILT_MAX = 4'(FILTER_LEN - 1);
   localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state, state_nxt;
   logic [1:0]      clk_sync, data_sync;
   logic            clk_filt, data_filt, clk_filt_q;
   logic [3:0]      clk_cnt, data_cnt;
   logic [3:0]      bitcnt;
   logic [9:0]      sr;
   logic [TO_W-1:0] to_cnt;
   logic            ext_flag, rel_flag;
   logic            scan_received_r, frame_error_r, extended_r, released_r;
   logic [7:0]      scan_r;

   logic            fe, timeout, frame_ok, is_prefix, is_resp;
   logic [7:0]      rx_byte;

   // Synchroniser and filter: a line only changes level after FILTER_LEN
   // consecutive synchronised samples disagree with the current level.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         clk_filt   <= 1'b1;
         data_filt  <= 1'b1;
         clk_filt_q <= 1'b1;
         clk_cnt    <= '0;
         data_cnt   <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], bus.ps2clk_in};
         data_sync  <= {data_sync[0], bus.ps2data_in};
         clk_filt_q <= clk_filt;

         if (clk_sync[1] == clk_filt) begin
            clk_cnt <= '0;
         end else if (clk_cnt == FILT_MAX) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= '0;
         end else begin
            clk_cnt <= clk_cnt + 4'd1;
         end

         if (data_sync[1] == data_filt) begin
            data_cnt <= '0;
         end else if (data_cnt == FILT_MAX) begin
            data_filt <= data_sync[1];
            data_cnt  <= '0;
         end else begin
            data_cnt <= data_cnt + 4'd1;
         end
      end
   end

   assign fe       = clk_filt_q & ~clk_filt;
   // Timeout only fires on a cycle without a falling edge, so an edge that
   // arrives exactly at the limit still counts as a live bit.
   assign timeout  = (state == RECV) && !fe && (to_cnt == TO_MAX);
   // After ten shifts: sr[7:0] data, sr[8] parity, sr[9] stop.
   assign rx_byte  = sr[7:0];
   assign frame_ok = (^sr[8:0]) & sr[9];
   assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
   assign is_resp   = rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fe && !data_filt) state_nxt = RECV;
         RECV: begin
            if (timeout)                       state_nxt = IDLE;
            else if (fe && bitcnt == 4'd10)    state_nxt = CHECK;
         end
         CHECK:   state_nxt = frame_ok ? DECODE : IDLE;
         DECODE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath. The event outputs are loaded on the CHECK->DECODE edge so the
   // strobe is visible during DECODE, two cycles after the stop-bit edge;
   // prefix flags are updated in DECODE itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         bitcnt          <= '0;
         sr              <= '0;
         to_cnt          <= '0;
         ext_flag        <= 1'b0;
         rel_flag        <= 1'b0;
         scan_received_r <= 1'b0;
         frame_error_r   <= 1'b0;
         scan_r          <= 8'h00;
         extended_r      <= 1'b0;
         released_r      <= 1'b0;
      end else begin
         scan_received_r <= 1'b0;
         frame_error_r   <= 1'b0;
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (fe && !data_filt) begin
                  bitcnt <= 4'd1;
                  sr     <= '0;
               end
            end
            RECV: begin
               if (fe) begin
                  sr     <= {data_filt, sr[9:1]};
                  bitcnt <= bitcnt + 4'd1;
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
               if (timeout) begin
                  frame_error_r <= 1'b1;
                  ext_flag      <= 1'b0;
                  rel_flag      <= 1'b0;
               end
            end
            CHECK: begin
               if (!frame_ok) begin
                  frame_error_r <= 1'b1;
                  ext_flag      <= 1'b0;
                  rel_flag      <= 1'b0;
               end else if (!is_prefix && !is_resp) begin
                  scan_received_r <= 1'b1;
                  scan_r          <= rx_byte;
                  extended_r      <= ext_flag;
                  released_r      <= rel_flag;
               end
            end
            DECODE: begin
               if (rx_byte == 8'hE0) begin
                  ext_flag <= 1'b1;
               end else if (rx_byte == 8'hF0) begin
                  rel_flag <= 1'b1;
               end else begin
                  ext_flag <= 1'b0;
                  rel_flag <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.scan_received = scan_received_r;
   assign bus.frame_error   = frame_error_r;
   assign bus.scan          = scan_r;
   assign bus.extended      = extended_r;
   assign bus.released      = released_r;
   assign bus.busy          = (state != IDLE);
   assign bus.state_dbg     = state;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb_ps2_scancode_receiver
//   Drives PS/2 frames (directed and random) into ps2_scancode_receiver and
//   checks events/errors against a byte-level model through a scoreboard.
module tb_ps2_scancode_receiver;
   localparam int FL = 8;
   localparam int TO = 1000;
   localparam logic [10:0] ERR_ENTRY = 11'h400;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   stop_cyc = 0;

   logic [10:0] exp_q[$];
   logic        m_ext = 1'b0;
   logic        m_rel = 1'b0;

   ps2_scancode_receiver_if bus ();

   ps2_scancode_receiver #(
      .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .TO_W(16)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad);
      logic par;
      par = ~(^b) ^ bad;
      return {1'b1, par, b, 1'b0};
   endfunction

   // Sends the first nbits of a frame; optional clock glitches on bit 4.
   task automatic send_bits(input logic [10:0] frame, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         bus.ps2data_in = frame[i];
         if (glitch && i == 4) begin
            wait_clk(3); bus.ps2clk_in = 1'b0;
            wait_clk(3); bus.ps2clk_in = 1'b1;
            wait_clk(4);
         end else begin
            wait_clk(10);
         end
         if (i == 10) stop_cyc = cyc;
         bus.ps2clk_in = 1'b0;
         if (glitch && i == 4) begin
            wait_clk(8);  bus.ps2clk_in = 1'b1;
            wait_clk(3);  bus.ps2clk_in = 1'b0;
            wait_clk(9);
         end else begin
            wait_clk(20);
         end
         bus.ps2clk_in = 1'b1;
         wait_clk(10);
      end
   endtask

   // Reference model at byte level: decide the expected response, then send.
   task automatic send_byte(input logic [7:0] b, input bit bad, input bit glitch);
      if (bad) begin
         exp_q.push_back(ERR_ENTRY);
         m_ext = 1'b0; m_rel = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_rel = 1'b1;
      end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
         m_ext = 1'b0; m_rel = 1'b0;
      end else begin
         exp_q.push_back({1'b0, m_ext, m_rel, b});
         m_ext = 1'b0; m_rel = 1'b0;
      end
      send_bits(make_frame(b, bad), 11, glitch);
      wait_clk(30);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [10:0] got, e;
      if (!rst && (bus.scan_received || bus.frame_error)) begin
         got = bus.frame_error ? ERR_ENTRY : {1'b0, bus.extended, bus.released, bus.scan};
         checks++;
         if (bus.scan_received && bus.frame_error) begin
            errors++;
            $display("FAIL both_strobes: got scan_received=1 frame_error=1, required one");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %0h, required nothing", got);
         end else begin
            e = exp_q.pop_front();
            if (got != e) begin
               errors++;
               $display("FAIL event: got %0h, required %0h", got, e);
            end
         end
         if (bus.scan_received) begin
            checks++;
            if (cyc - stop_cyc != FL + 4) begin
               errors++;
               $display("FAIL latency: got %0d, required %0d", cyc - stop_cyc, FL + 4);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int w;
      bus.ps2clk_in  = 1'b1;
      bus.ps2data_in = 1'b1;
      rst = 1'b1;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(2);
      chk("rst_scan", bus.scan, 8'h00);
      chk("rst_ext", bus.extended, 0);
      chk("rst_rel", bus.released, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_strobe", bus.scan_received, 0);
      chk("rst_ferr", bus.frame_error, 0);

      // 1: plain make code
      send_byte(8'h1C, 1'b0, 1'b0);
      // 2: E0 F0 prefix combination, then flags clear
      send_byte(8'hE0, 1'b0, 1'b0);
      send_byte(8'hF0, 1'b0, 1'b0);
      send_byte(8'h75, 1'b0, 1'b0);
      send_byte(8'h75, 1'b0, 1'b0);
      // repeated E0
      send_byte(8'hE0, 1'b0, 1'b0);
      send_byte(8'hE0, 1'b0, 1'b0);
      send_byte(8'h4A, 1'b0, 1'b0);
      // 3: parity error drops prefix
      send_byte(8'hE0, 1'b0, 1'b0);
      send_byte(8'h1C, 1'b1, 1'b0);
      send_byte(8'hF0, 1'b0, 1'b0);
      send_byte(8'h1C, 1'b0, 1'b0);
      // prefix lost by a suppressed byte
      send_byte(8'hF0, 1'b0, 1'b0);
      send_byte(8'hFA, 1'b0, 1'b0);
      send_byte(8'h2B, 1'b0, 1'b0);

      // 4: timeout abort after 5 bits
      exp_q.push_back(ERR_ENTRY);
      m_ext = 1'b0; m_rel = 1'b0;
      send_bits(make_frame(8'h29, 1'b0), 5, 1'b0);
      chk("busy_mid_frame", bus.busy, 1);
      wait_clk(TO + 50);
      chk("busy_after_timeout", bus.busy, 0);
      send_byte(8'h29, 1'b0, 1'b0);

      // 5: glitches while idle, then a frame with mid-bit glitches
      for (int g = 0; g < 3; g++) begin
         bus.ps2clk_in = 1'b0; wait_clk(3);
         bus.ps2clk_in = 1'b1; wait_clk(15);
      end
      chk("glitch_busy", bus.busy, 0);
      chk("glitch_state", bus.state_dbg, 0);
      send_byte(8'h5A, 1'b0, 1'b1);

      // 6: reset mid-frame clears the pending prefix
      send_byte(8'hE0, 1'b0, 1'b0);
      send_bits(make_frame(8'hE0, 1'b0), 6, 1'b0);
      rst = 1'b1;
      m_ext = 1'b0; m_rel = 1'b0;
      wait_clk(3);
      chk("rst2_scan", bus.scan, 8'h00);
      chk("rst2_busy", bus.busy, 0);
      chk("rst2_ext", bus.extended, 0);
      rst = 1'b0;
      bus.ps2data_in = 1'b1;
      wait_clk(30);
      send_byte(8'h6B, 1'b0, 1'b0);
      send_byte(8'hAA, 1'b0, 1'b0);

      // random traffic
      for (int n = 0; n < 25; n++) begin
         int r;
         logic [7:0] b;
         r = $urandom_range(0, 9);
         if (r < 2)       b = 8'hE0;
         else if (r == 2) b = 8'hF0;
         else if (r == 3) b = 8'hEE;
         else             b = 8'($urandom_range(0, 255));
         send_byte(b, ($urandom_range(0, 9) == 0), 1'b0);
      end

      w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
         wait_clk(1);
         w++;
      end
      chk("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
